// File: rtl/fp16_int_arith_unit_if.sv
// Operand/result bundle between the FP16 alignment stage, the integer arithmetic unit and normalisation.
interface fp16_int_arith_unit_if #(
  parameter int W_WIDE   = 12,
  parameter int W_NARROW = 6
);
  logic                in_valid;
  logic [W_WIDE-1:0]   add_a;
  logic [W_WIDE-1:0]   add_b;
  logic [W_WIDE-1:0]   sub_a;
  logic [W_WIDE-1:0]   sub_b;
  logic [W_NARROW-1:0] exp_a;
  logic [W_NARROW-1:0] exp_b;
  logic                out_valid;
  logic [W_WIDE-1:0]   add_sum;
  logic [W_WIDE-1:0]   sub_diff;
  logic [W_NARROW-1:0] exp_sum;
  logic                add_cout;
  logic                sub_borrow;
  logic                exp_ovf;

  modport master (
    output in_valid, add_a, add_b, sub_a, sub_b, exp_a, exp_b,
    input  out_valid, add_sum, sub_diff, exp_sum, add_cout, sub_borrow, exp_ovf
  );

  modport slave (
    input  in_valid, add_a, add_b, sub_a, sub_b, exp_a, exp_b,
    output out_valid, add_sum, sub_diff, exp_sum, add_cout, sub_borrow, exp_ovf
  );
endinterface

// File: rtl/fp16_int_arith_unit.sv
// Registered mantissa add/sub and exponent add lanes for the FP16 adder, one-cycle latency.
// Define FP16_ARITH_FLAGS_EN to build the carry, borrow and exponent-overflow flags.
module fp16_int_arith_unit #(
  parameter int W_WIDE   = 12,
  parameter int W_NARROW = 6
) (
  input logic                 clk,
  input logic                 rst,
  fp16_int_arith_unit_if.slave bus
);

  function automatic logic [W_WIDE:0] adder_12bit(input logic [W_WIDE-1:0] a,
                                                  input logic [W_WIDE-1:0] b,
                                                  input logic              cin);
    return {1'b0, a} + {1'b0, b} + {{W_WIDE{1'b0}}, cin};
  endfunction

  // Result MSB is the borrow: inverse of the carry out of a + ~b + 1.
  function automatic logic [W_WIDE:0] subtractor_12bit(input logic [W_WIDE-1:0] a,
                                                       input logic [W_WIDE-1:0] b);
    logic [W_WIDE:0] r;
    r = adder_12bit(a, ~b, 1'b1);
    return {~r[W_WIDE], r[W_WIDE-1:0]};
  endfunction

  function automatic logic [W_NARROW-1:0] adder_6bit(input logic [W_NARROW-1:0] a,
                                                     input logic [W_NARROW-1:0] b);
    return a + b;
  endfunction

  logic [W_WIDE-1:0]   add_sum_s, sub_diff_s;
  logic [W_NARROW-1:0] exp_sum_s;
  logic                valid_d, valid_q;
  logic [W_WIDE-1:0]   add_sum_d, add_sum_q, sub_diff_d, sub_diff_q;
  logic [W_NARROW-1:0] exp_sum_d, exp_sum_q;

`ifdef FP16_ARITH_FLAGS_EN
  logic add_cout_s, sub_borrow_s, exp_ovf_s;
  logic add_cout_d, add_cout_q, sub_borrow_d, sub_borrow_q, exp_ovf_d, exp_ovf_q;

  // Lane arithmetic with flags.
  always_comb begin
    {add_cout_s, add_sum_s}     = adder_12bit(bus.add_a, bus.add_b, 1'b0);
    {sub_borrow_s, sub_diff_s}  = subtractor_12bit(bus.sub_a, bus.sub_b);
    exp_sum_s                   = adder_6bit(bus.exp_a, bus.exp_b);
    exp_ovf_s = (bus.exp_a[W_NARROW-1] == bus.exp_b[W_NARROW-1]) &&
                (exp_sum_s[W_NARROW-1] != bus.exp_a[W_NARROW-1]);
  end
`else
  // Lane arithmetic, data only.
  always_comb begin
    add_sum_s  = W_WIDE'(adder_12bit(bus.add_a, bus.add_b, 1'b0));
    sub_diff_s = W_WIDE'(subtractor_12bit(bus.sub_a, bus.sub_b));
    exp_sum_s  = adder_6bit(bus.exp_a, bus.exp_b);
  end
`endif

  // Next state: capture on a valid beat, otherwise hold data while valid drops.
  always_comb begin
    valid_d    = bus.in_valid;
    add_sum_d  = add_sum_q;
    sub_diff_d = sub_diff_q;
    exp_sum_d  = exp_sum_q;
`ifdef FP16_ARITH_FLAGS_EN
    add_cout_d   = add_cout_q;
    sub_borrow_d = sub_borrow_q;
    exp_ovf_d    = exp_ovf_q;
`endif
    if (bus.in_valid) begin
      add_sum_d  = add_sum_s;
      sub_diff_d = sub_diff_s;
      exp_sum_d  = exp_sum_s;
`ifdef FP16_ARITH_FLAGS_EN
      add_cout_d   = add_cout_s;
      sub_borrow_d = sub_borrow_s;
      exp_ovf_d    = exp_ovf_s;
`endif
    end else begin
      valid_d = 1'b0;
    end
  end

  // Output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      add_sum_q  <= {W_WIDE{1'b0}};
      sub_diff_q <= {W_WIDE{1'b0}};
      exp_sum_q  <= {W_NARROW{1'b0}};
`ifdef FP16_ARITH_FLAGS_EN
      add_cout_q   <= 1'b0;
      sub_borrow_q <= 1'b0;
      exp_ovf_q    <= 1'b0;
`endif
    end else begin
      valid_q    <= valid_d;
      add_sum_q  <= add_sum_d;
      sub_diff_q <= sub_diff_d;
      exp_sum_q  <= exp_sum_d;
`ifdef FP16_ARITH_FLAGS_EN
      add_cout_q   <= add_cout_d;
      sub_borrow_q <= sub_borrow_d;
      exp_ovf_q    <= exp_ovf_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.add_sum   = add_sum_q;
  assign bus.sub_diff  = sub_diff_q;
  assign bus.exp_sum   = exp_sum_q;
`ifdef FP16_ARITH_FLAGS_EN
  assign bus.add_cout   = add_cout_q;
  assign bus.sub_borrow = sub_borrow_q;
  assign bus.exp_ovf    = exp_ovf_q;
`else
  assign bus.add_cout   = 1'b0;
  assign bus.sub_borrow = 1'b0;
  assign bus.exp_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_fp16_int_arith_unit.sv
// Bench for fp16_int_arith_unit: directed corner beats plus a random stream against an integer model.
module tb_fp16_int_arith_unit;

  localparam int W_WIDE   = 12;
  localparam int W_NARROW = 6;
`ifdef FP16_ARITH_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // Reference state: what the outputs must show after the most recent edge.
  int m_valid, m_sum, m_cout, m_diff, m_borrow, m_esum, m_ovf;

  fp16_int_arith_unit_if #(.W_WIDE(W_WIDE), .W_NARROW(W_NARROW)) bus_if ();

  fp16_int_arith_unit #(.W_WIDE(W_WIDE), .W_NARROW(W_NARROW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check_value({tag, ".out_valid"},  32'(bus_if.out_valid),  32'(m_valid));
    check_value({tag, ".add_sum"},    32'(bus_if.add_sum),    32'(m_sum));
    check_value({tag, ".sub_diff"},   32'(bus_if.sub_diff),   32'(m_diff));
    check_value({tag, ".exp_sum"},    32'(bus_if.exp_sum),    32'(m_esum));
    check_value({tag, ".add_cout"},   32'(bus_if.add_cout),   32'(m_cout));
    check_value({tag, ".sub_borrow"}, 32'(bus_if.sub_borrow), 32'(m_borrow));
    check_value({tag, ".exp_ovf"},    32'(bus_if.exp_ovf),    32'(m_ovf));
  endtask

  task automatic model_reset();
    m_valid = 0; m_sum = 0; m_cout = 0; m_diff = 0; m_borrow = 0; m_esum = 0; m_ovf = 0;
  endtask

  // Integer model of one clock edge for the given inputs.
  task automatic model_edge(input logic v, input int aa, input int ab, input int sa, input int sb,
                            input int ea, input int eb);
    int sea, seb, ssum;
    m_valid = v ? 1 : 0;
    if (v) begin
      m_sum  = (aa + ab) % 4096;
      m_diff = (sa - sb + 4096) % 4096;
      m_esum = (ea + eb) % 64;
      sea    = (ea >= 32) ? ea - 64 : ea;
      seb    = (eb >= 32) ? eb - 64 : eb;
      ssum   = sea + seb;
      m_cout   = (FLAGS_ON && (aa + ab) > 4095) ? 1 : 0;
      m_borrow = (FLAGS_ON && sb > sa) ? 1 : 0;
      m_ovf    = (FLAGS_ON && (ssum > 31 || ssum < -32)) ? 1 : 0;
    end
  endtask

  task automatic drive(input logic v, input int aa, input int ab, input int sa, input int sb,
                       input int ea, input int eb);
    bus_if.in_valid = v;
    bus_if.add_a = 12'(aa);
    bus_if.add_b = 12'(ab);
    bus_if.sub_a = 12'(sa);
    bus_if.sub_b = 12'(sb);
    bus_if.exp_a = 6'(ea);
    bus_if.exp_b = 6'(eb);
  endtask

  task automatic beat(input string tag, input logic v, input int aa, input int ab, input int sa,
                      input int sb, input int ea, input int eb);
    @(negedge clk);
    drive(v, aa, ab, sa, sb, ea, eb);
    @(posedge clk);
    model_edge(v, aa, ab, sa, sb, ea, eb);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed corners.
    beat("add_basic", 1'b1, 12'h400, 12'h400, 12'h600, 12'h400, 6'h0F, 6'h3F);
    beat("add_wrap",  1'b1, 12'hFFF, 12'h001, 12'h000, 12'h001, 6'h0F, 6'h01);
    beat("exp_noovf", 1'b1, 12'h123, 12'h456, 12'h456, 12'h123, 6'h1F, 6'h36);
    beat("exp_ovf",   1'b1, 12'hFFF, 12'hFFF, 12'h7FF, 12'h800, 6'h1F, 6'h01);
    beat("exp_negovf", 1'b1, 12'h800, 12'h800, 12'hFFF, 12'hFFF, 6'h20, 6'h3F);

    // Three back-to-back beats, then two idle cycles with changing operands.
    beat("stream0", 1'b1, 12'h111, 12'h222, 12'h333, 12'h044, 6'h05, 6'h06);
    beat("stream1", 1'b1, 12'hABC, 12'h654, 12'h100, 12'h200, 6'h2A, 6'h2B);
    beat("stream2", 1'b1, 12'h7FF, 12'h801, 12'h555, 12'h555, 6'h10, 6'h10);
    beat("idle0",   1'b0, 12'hFFF, 12'hFFF, 12'h000, 12'hFFF, 6'h3F, 6'h3F);
    beat("idle1",   1'b0, 12'h001, 12'h002, 12'h003, 12'h004, 6'h01, 6'h02);

    // Asynchronous reset in the middle of a valid beat.
    beat("pre_rst", 1'b1, 12'h321, 12'h123, 12'h800, 12'h801, 6'h1F, 6'h01);
    @(negedge clk);
    drive(1'b1, 12'hFFF, 12'h001, 12'h000, 12'h001, 6'h1F, 6'h01);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 check_all("rst_held");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 12'h400, 12'h400, 12'h600, 12'h400, 6'h0F, 6'h01);
    #1 check_value("post_rst_pre_edge.out_valid", 32'(bus_if.out_valid), 32'd0);
    @(posedge clk);
    model_edge(1'b1, 12'h400, 12'h400, 12'h600, 12'h400, 6'h0F, 6'h01);
    #1 check_all("post_rst_first");

    // Random stream with random in_valid gaps.
    for (int i = 0; i < 300; i++) begin
      beat("rand", 1'($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
           int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
